// File: rtl/la_wb_pkg.sv
// Shared types and constants for the logic-analyzer Wishbone initiator.
package la_wb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  // Data returned with writes and with timeout aborts
  localparam int unsigned RSP_ERR_DATA = 0;
endpackage

// File: rtl/la_wb_master_if.sv
// Command/response stream and Wishbone master bus of la_wb_master.
interface la_wb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [DW-1:0] rsp_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o, wbm_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
           rsp_ready_i, wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
           rsp_ready_i, wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/la_wb_timeout.sv
// Saturating bus-wait counter; expired flags the last allowed strobe cycle.
module la_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= '0;
    else if (clr)                      cnt_q <= '0;
    else if (en && cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/la_wb_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command
// stream; one response per command, with timeout abort on a silent slave.
module la_wb_master
  import la_wb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  la_wb_master_if.master        bus,
  output logic                  busy_o
);
  localparam int SW = DW / 8;

  state_t        state_q, state_d;
  logic          accept, done_ack, done_to, expired;
  logic          we_q, err_q;
  logic [SW-1:0] sel_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q, rdat_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid_i) begin
        accept  = 1'b1;
        state_d = BUS;
      end
      // ack beats the timeout when both land in the same cycle
      BUS: if (bus.wbm_ack_i) begin
        done_ack = 1'b1;
        state_d  = RESP;
      end else if (expired) begin
        done_to = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  la_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clr     (accept),
    .en      (state_q == BUS && !bus.wbm_ack_i),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        we_q   <= bus.cmd_we_i;
        sel_q  <= bus.cmd_sel_i;
        adr_q  <= bus.cmd_adr_i;
        wdat_q <= bus.cmd_dat_i;
      end
      if (done_ack) begin
        rdat_q <= we_q ? DW'(RSP_ERR_DATA) : bus.wbm_dat_i;
        err_q  <= 1'b0;
      end else if (done_to) begin
        rdat_q <= DW'(RSP_ERR_DATA);
        err_q  <= 1'b1;
      end
    end
  end

  // Ready is masked by reset so nothing looks acceptable while reset is held
  assign bus.cmd_ready_o = (state_q == IDLE) && wb_rst_ni;
  assign bus.wbm_cyc_o   = (state_q == BUS);
  assign bus.wbm_stb_o   = (state_q == BUS);
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = wdat_q;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_dat_o   = rdat_q;
  assign bus.rsp_err_o   = err_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_la_wb_master.sv
// Directed bench for la_wb_master: vector table of transfers plus
// backpressure/stray-ack and asynchronous-reset sequences.
module tb_la_wb_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  la_wb_master_if #(.AW(32), .DW(32)) bus ();

  la_wb_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .busy_o    (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack_en;
    int          ack_cyc;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_stb;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = v.we;
    bus.cmd_adr_i   = v.adr;
    bus.cmd_dat_i   = v.dat;
    bus.cmd_sel_i   = v.sel;
    bus.rsp_ready_i = 1'b0;
    check({tag, " cmd_ready idle"}, 64'(bus.cmd_ready_o), 64'd1);
    @(posedge clk); #1;
    // scramble command inputs: the bus side must hold the captured values
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = ~v.adr;
    bus.cmd_dat_i   = ~v.dat;
    bus.cmd_sel_i   = ~v.sel;
    bus.cmd_we_i    = ~v.we;
    while (bus.wbm_stb_o === 1'b1 && n < 40) begin
      n++;
      if (bus.wbm_adr_o !== v.adr || bus.wbm_dat_o !== v.dat ||
          bus.wbm_sel_o !== v.sel || bus.wbm_we_o !== v.we || bus.wbm_cyc_o !== 1'b1)
        check({tag, " bus hold"}, {bus.wbm_adr_o, bus.wbm_dat_o}, {v.adr, v.dat});
      bus.wbm_dat_i = v.rdata;
      bus.wbm_ack_i = v.ack_en && (n == v.ack_cyc);
      @(posedge clk); #1;
      bus.wbm_ack_i = 1'b0;
    end
    check({tag, " stb cycles"}, 64'(n), 64'(v.exp_stb));
    check({tag, " rsp_valid"}, 64'(bus.rsp_valid_o), 64'd1);
    check({tag, " rsp_dat"}, 64'(bus.rsp_dat_o), 64'(v.exp_dat));
    check({tag, " rsp_err"}, 64'(bus.rsp_err_o), 64'(v.exp_err));
    check({tag, " ready in RESP"}, {63'd0, bus.cmd_ready_o}, 64'd0);
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check({tag, " idle after rsp"}, {62'd0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd1);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
    bus.cmd_dat_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b0;
    bus.wbm_ack_i = 1'b0; bus.wbm_dat_i = '0;

    //        we    adr           dat           sel   ack  cyc rdata         exp_dat       err  stb
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b1, 1, 32'h1111_2222, 32'h0,         1'b0, 1};
    vecs[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 1'b1, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 1'b0, 0, 32'h5555_AAAA, 32'h0,         1'b1, 8};
    vecs[3] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 8, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 8};
    vecs[4] = '{1'b1, 32'h3000_0020, 32'hCAFE_0001, 4'h3, 1'b0, 0, 32'h7777_7777, 32'h0,         1'b1, 8};
    vecs[5] = '{1'b0, 32'h3000_0024, 32'h0,         4'h1, 1'b1, 7, 32'h1234_5678, 32'h1234_5678, 1'b0, 7};

    #12;
    check("reset ready", 64'(bus.cmd_ready_o), 64'd0);
    check("reset outs", {59'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.rsp_err_o, busy}, 64'd0);
    check("reset bus", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ready after reset", 64'(bus.cmd_ready_o), 64'd1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with stray acks and a pending command in RESP
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 32'h3000_0030;
    bus.cmd_sel_i = 4'hF; bus.wbm_dat_i = 32'h600D_D00D; bus.wbm_ack_i = 1'b1;
    @(posedge clk); #1;
    check("bp stb", 64'(bus.wbm_stb_o), 64'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hBAD0_0000 + 32'(c);
      @(posedge clk); #1;
      check($sformatf("bp hold%0d", c),
            {bus.rsp_dat_o, 27'd0, bus.rsp_valid_o, bus.rsp_err_o, bus.cmd_ready_o, bus.wbm_stb_o, bus.wbm_cyc_o},
            {32'h600D_D00D, 27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    bus.wbm_ack_i = 1'b0; bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check("bp release", {62'd0, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd1);

    // Asynchronous reset in the middle of a strobe
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 32'h3000_0040;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    @(posedge clk); #3;
    check("pre-reset stb", 64'(bus.wbm_stb_o), 64'd1);
    rst_n = 1'b0; #1;
    check("async drop", {60'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, busy}, 64'd0);
    check("async ready", 64'(bus.cmd_ready_o), 64'd0);
    check("async adr", 64'(bus.wbm_adr_o), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    check("post-reset", {61'd0, bus.rsp_valid_o, bus.wbm_stb_o, bus.cmd_ready_o}, 64'd1);
    run_txn(vecs[1], "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/la_wb_master.md
Name: la_wb_master

Overview:
- Wishbone classic single-transfer initiator; the requesting end of the Wishbone slave interface that the user-area blocks (e.g. ADC control wrapper) expose.
- Converts a valid/ready command stream into one Wishbone read or write per command and returns a response with data or an error flag.
- Intended to be driven from logic-analyzer bits or a local sequencer, so on-chip slaves can be exercised without the management SoC.
- Includes a bus timeout so that a missing slave cannot hang the requester.

Parameters:
- AW, 32, address width
- DW, 32, data width (a multiple of 8; SW = DW/8)
- TIMEOUT, 255, cycles of asserted stb without ack before abort; 0 disables the timeout

Ports:
- wb_clk_i  in  1  clock; the block's only clock
- wb_rst_ni  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  block can accept a command
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  AW  byte address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  SW  byte lane enables
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  requester consumes the response
- rsp_dat_o  out  DW  read data; 0 for writes and errors
- rsp_err_o  out  1  1 = timeout abort
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  SW  Wishbone byte select
- wbm_adr_o  out  AW  Wishbone address
- wbm_dat_o  out  DW  Wishbone write data
- wbm_ack_i  in  1  Wishbone acknowledge
- wbm_dat_i  in  DW  Wishbone read data
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, wb_rst_ni low):
  - All outputs go to 0 immediately, except cmd_ready_o, which is 0 while reset is held and 1 in IDLE after reset releases.
  - State returns to IDLE and the timeout counter clears.
  - Reset mid-transfer drops wbm_cyc_o and wbm_stb_o at once; no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i && cmd_ready_o, register we/adr/dat/sel into the wbm_* outputs, clear the counter, and go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1.
  - wbm_we/sel/adr/dat are held stable for the whole transfer; cmd_ready_o = 0.
  - The counter increments each cycle with wbm_ack_i low.
  - wbm_ack_i high: capture rsp_dat_o = wbm_dat_i for a read (0 for a write), set rsp_err_o = 0, and go to RESP.
  - No ack and counter == TIMEOUT-1 (TIMEOUT != 0): set rsp_dat_o = 0, rsp_err_o = 1, and go to RESP.
  - Ack in the same cycle as the timeout limit: the ack wins and no error is flagged.
- RESP:
  - cyc/stb = 0 and rsp_valid_o = 1.
  - rsp_dat_o and rsp_err_o stay stable until rsp_valid_o && rsp_ready_i.
  - When that handshake occurs, go to IDLE.
- wbm_ack_i is ignored in IDLE and RESP; a stray ack has no effect.
- Latency: a command accepted at edge N gives stb high in cycle N+1. With a zero-wait ack in N+1, rsp_valid_o is high in N+2. If rsp_ready_i is held high, cmd_ready_o is high again in N+3.
- Throughput: at most one transfer outstanding; no pipelining and no back-to-back stb.
- Counter width: $clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.
- The registered wbm_* outputs are combinationally independent of the cmd_* inputs.

Decomposition:
- Package la_wb_pkg:
  - state enum (IDLE, BUS, RESP)
  - default width and TIMEOUT constants
  - RSP_ERR_DATA = 0
- Sub-module la_wb_timeout: a saturating counter with clear, enable, and an expired flag, parameterised by TIMEOUT. It must tie expired low when TIMEOUT = 0.

Test Plan:
1. Write, zero-wait:
   - Stimulus: cmd_we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks in the first stb cycle.
   - Response: one stb cycle with matching wbm_* outputs; rsp_valid two cycles after acceptance with err=0, dat=0.
2. Read, 3 wait states:
   - Stimulus: read adr=0x3000_0008; slave returns 0xDEAD_BEEF with ack on the 4th stb cycle.
   - Response: stb high 4 cycles; rsp_dat=0xDEAD_BEEF, err=0; adr stable throughout.
3. Timeout:
   - Stimulus: TIMEOUT=8; read with no ack.
   - Response: stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0; cmd_ready returns only after the rsp handshake.
4. Ack on the timeout limit:
   - Stimulus: TIMEOUT=8; ack arrives in the 8th stb cycle.
   - Response: err=0 and data captured.
5. Backpressure and stray ack:
   - Stimulus: rsp_ready held low 5 cycles; ack pulses while in RESP; a new cmd_valid is presented.
   - Response: rsp fields stable, cmd_ready=0, no second stb.
6. Reset mid-BUS:
   - Stimulus: wb_rst_ni low asynchronously during stb, then released.
   - Response: cyc/stb fall without a clock edge; no rsp_valid; cmd_ready=1 after release; the next read completes normally.
